// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TX shifter, mid-bit-sampling RX, small RX FIFO and a
// registered level interrupt, all on a single clock with synchronous reset.
module uart_periph #(
  parameter int CLK_DIV_DEFAULT = 434,
  parameter int RX_FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_cmd_sel,
  input  logic        mem_cmd_valid,
  input  logic        mem_cmd_wr,
  input  logic [11:0] mem_cmd_addr,
  input  logic [31:0] mem_cmd_wdata,
  output logic        mem_rsp_ready,
  output logic [31:0] mem_rsp_rdata,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);

  localparam int PTR_W = $clog2(RX_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0] DIV_RESET = 16'(CLK_DIV_DEFAULT);
  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(RX_FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Bus decode
  logic       cmd_acc, cmd_hit, rd_acc, rd_hit, wr_hit;
  logic [1:0] reg_sel;

  assign cmd_acc = mem_cmd_valid & mem_cmd_sel;
  assign cmd_hit = cmd_acc & (mem_cmd_addr[11:4] == 8'd0);
  assign rd_acc  = cmd_acc & ~mem_cmd_wr;
  assign rd_hit  = cmd_hit & ~mem_cmd_wr;
  assign wr_hit  = cmd_hit & mem_cmd_wr;
  assign reg_sel = mem_cmd_addr[3:2];

  logic unused_bits;
  assign unused_bits = ^{mem_cmd_addr[1:0], mem_cmd_wdata[31:16]};

  // Configuration and sticky status
  logic [15:0] div_q, div_d, div_eff;
  logic        irq_en_q, irq_en_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_set, frame_err_set;

  // Divisors below 4 would make the half-bit wait degenerate
  assign div_eff = (div_q < 16'd4) ? 16'd4 : div_q;

  always_comb begin
    div_d       = div_q;
    irq_en_d    = irq_en_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (wr_hit && reg_sel == 2'd2) div_d = mem_cmd_wdata[15:0];
    if (wr_hit && reg_sel == 2'd3) irq_en_d = mem_cmd_wdata[0];
    if (wr_hit && reg_sel == 2'd1) begin
      if (mem_cmd_wdata[3]) overrun_d = 1'b0;
      if (mem_cmd_wdata[4]) frame_err_d = 1'b0;
    end
    if (overrun_set) overrun_d = 1'b1;
    if (frame_err_set) frame_err_d = 1'b1;
  end

  // Transmitter
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_out_q, tx_out_d;
  logic        tx_busy, tx_load, tx_last;

  assign tx_busy = (tx_state_q != TX_IDLE);
  assign tx_load = wr_hit && (reg_sel == 2'd0) && !tx_busy;
  assign tx_last = (tx_cnt_q == tx_div_q - 16'd1);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_out_d   = tx_out_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_load) begin
          tx_state_d = TX_START;
          tx_cnt_d   = 16'd0;
          tx_div_d   = div_eff;
          tx_shift_d = mem_cmd_wdata[7:0];
          tx_out_d   = 1'b0;
        end
      end
      TX_START: begin
        if (tx_last) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
          tx_out_d   = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_last) begin
          tx_cnt_d = 16'd0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_out_d   = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_out_d   = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_last) begin
          tx_state_d = TX_IDLE;
          tx_out_d   = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_out_d   = 1'b1;
      end
    endcase
  end

  // Receiver: sync[0], sync[1] form the synchronizer, sync[2] is the edge history
  logic [2:0]  rx_sync_q, rx_sync_d;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] rx_div_q, rx_div_d;
  logic [15:0] rx_half;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_in, rx_fall, rx_last, rx_half_last, rx_stop_ok;

  assign rx_sync_d    = {rx_sync_q[1:0], uart_rx};
  assign rx_in        = rx_sync_q[1];
  assign rx_fall      = rx_sync_q[2] & ~rx_sync_q[1];
  assign rx_half      = {1'b0, rx_div_q[15:1]};
  assign rx_last      = (rx_cnt_q == rx_div_q - 16'd1);
  assign rx_half_last = (rx_cnt_q == rx_half - 16'd1);

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_div_d      = rx_div_q;
    rx_shift_d    = rx_shift_q;
    rx_bit_d      = rx_bit_q;
    rx_stop_ok    = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_START;
          rx_cnt_d   = 16'd0;
          rx_div_d   = div_eff;
        end
      end
      RX_START: begin
        if (rx_half_last) begin
          rx_cnt_d   = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_in ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_last) begin
          rx_cnt_d   = 16'd0;
          rx_shift_d = {rx_in, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_last) begin
          rx_state_d    = RX_IDLE;
          rx_stop_ok    = rx_in;
          frame_err_set = ~rx_in;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX FIFO; a pop in the same cycle frees the slot for an incoming byte
  logic [7:0]       fifo_mem_q [RX_FIFO_DEPTH];
  logic [7:0]       fifo_mem_d [RX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic             fifo_push, fifo_pop, rx_nonempty, rx_full;
  logic [7:0]       fifo_head;

  assign rx_nonempty = (fifo_cnt_q != '0);
  assign rx_full     = (fifo_cnt_q == FIFO_FULL_CNT);
  assign fifo_pop    = rd_hit && (reg_sel == 2'd0) && rx_nonempty;
  assign fifo_push   = rx_stop_ok && (!rx_full || fifo_pop);
  assign overrun_set = rx_stop_ok && rx_full && !fifo_pop;
  assign fifo_head   = fifo_mem_q[rd_ptr_q];

  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push) begin
      fifo_mem_d[wr_ptr_q] = rx_shift_q;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Read response and interrupt
  logic        rsp_ready_q, rsp_ready_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        irq_q, irq_d;

  always_comb begin
    rsp_ready_d = rd_acc;
    rsp_rdata_d = 32'd0;
    if (rd_hit) begin
      case (reg_sel)
        2'd0:    rsp_rdata_d = rx_nonempty ? {1'b1, 23'd0, fifo_head} : 32'd0;
        2'd1:    rsp_rdata_d = {27'd0, frame_err_q, overrun_q, rx_full, rx_nonempty, tx_busy};
        2'd2:    rsp_rdata_d = {16'd0, div_q};
        default: rsp_rdata_d = {31'd0, irq_en_q};
      endcase
    end
    irq_d = irq_en_q & rx_nonempty;
  end

  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= DIV_RESET;
      irq_en_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= 16'd0;
      tx_div_q    <= DIV_RESET;
      tx_shift_q  <= 8'd0;
      tx_bit_q    <= 3'd0;
      tx_out_q    <= 1'b1;
      rx_sync_q   <= 3'b111;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= 16'd0;
      rx_div_q    <= DIV_RESET;
      rx_shift_q  <= 8'd0;
      rx_bit_q    <= 3'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      rsp_ready_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      irq_q       <= 1'b0;
    end else begin
      div_q       <= div_d;
      irq_en_q    <= irq_en_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      tx_out_q    <= tx_out_d;
      rx_sync_q   <= rx_sync_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_shift_q  <= rx_shift_d;
      rx_bit_q    <= rx_bit_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_rdata_q <= rsp_rdata_d;
      irq_q       <= irq_d;
    end
  end

  assign mem_rsp_ready = rsp_ready_q;
  assign mem_rsp_rdata = rsp_rdata_q;
  assign uart_tx       = tx_out_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph: read responses are scoreboarded, TX
// frames are decoded against expected bytes, RX frames are driven bit by bit.
module tb_uart_periph;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_cmd_sel = 1'b0;
  logic        mem_cmd_valid = 1'b0;
  logic        mem_cmd_wr = 1'b0;
  logic [11:0] mem_cmd_addr = 12'd0;
  logic [31:0] mem_cmd_wdata = 32'd0;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic        uart_tx;
  logic        uart_rx = 1'b1;
  logic        irq;

  int checks = 0;
  int failures = 0;

  logic [31:0] rdExpQ[$];
  string       rdTagQ[$];
  logic [7:0]  txExpQ[$];
  int          txFrames = 0;
  bit          txMonEn = 1'b0;
  int          txDiv = 8;

  uart_periph dut (
    .clk           (clk),
    .reset         (reset),
    .mem_cmd_sel   (mem_cmd_sel),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_wr    (mem_cmd_wr),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_cmd_wdata (mem_cmd_wdata),
    .mem_rsp_ready (mem_rsp_ready),
    .mem_rsp_rdata (mem_rsp_rdata),
    .uart_tx       (uart_tx),
    .uart_rx       (uart_rx),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Called at a negedge; one bus cycle. Reads queue their expected response.
  task automatic applyStimulus(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                               input string tag);
    mem_cmd_sel   = 1'b1;
    mem_cmd_valid = 1'b1;
    mem_cmd_wr    = wr;
    mem_cmd_addr  = addr;
    mem_cmd_wdata = wr ? data : 32'd0;
    if (!wr) begin
      rdExpQ.push_back(data);
      rdTagQ.push_back(tag);
    end
    @(negedge clk);
    mem_cmd_sel   = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_wr    = 1'b0;
  endtask

  task automatic uartSend(input logic [7:0] b, input logic stopBit, input int div);
    uart_rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (div) @(negedge clk);
    end
    uart_rx = stopBit;
    repeat (div) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mem_rsp_ready) begin
      if (rdExpQ.size() == 0) begin
        checkOutput("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        checkOutput(rdTagQ.pop_front(), mem_rsp_rdata, rdExpQ.pop_front());
      end
    end
  end

  // TX decoder: checks first and last cycle of every bit of each frame
  initial begin : txDecoder
    logic       prevTx;
    logic [7:0] expByte;
    logic [9:0] frame;
    prevTx = 1'b1;
    forever begin
      @(negedge clk);
      if (txMonEn && prevTx && !uart_tx) begin
        txFrames++;
        if (txExpQ.size() == 0) begin
          checkOutput("tx_unexpected_frame", 32'd1, 32'd0);
          expByte = 8'hFF;
        end else begin
          expByte = txExpQ.pop_front();
        end
        frame = {1'b1, expByte, 1'b0};
        for (int k = 0; k < 10; k++) begin
          checkOutput($sformatf("tx_bit%0d_first", k), 32'(uart_tx), 32'(frame[k]));
          repeat (txDiv - 1) @(negedge clk);
          checkOutput($sformatf("tx_bit%0d_last", k), 32'(uart_tx), 32'(frame[k]));
          @(negedge clk);
        end
      end
      prevTx = uart_tx;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin : mainSeq
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkOutput("reset_uart_tx", 32'(uart_tx), 32'd1);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    checkOutput("reset_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    applyStimulus(1'b0, 12'h008, 32'h0000_01B2, "reset_div");
    applyStimulus(1'b0, 12'h004, 32'h0, "reset_status");
    applyStimulus(1'b0, 12'h00C, 32'h0, "reset_irq_en");
    applyStimulus(1'b0, 12'h000, 32'h0, "reset_data_empty");

    applyStimulus(1'b1, 12'h018, 32'h5, "");
    applyStimulus(1'b0, 12'h008, 32'h0000_01B2, "div_after_unmapped_wr");
    applyStimulus(1'b0, 12'h010, 32'h0, "unmapped_rd");
    applyStimulus(1'b1, 12'h008, 32'h1, "");
    applyStimulus(1'b0, 12'h008, 32'h1, "div_small_stored");

    // TX frame at DIV=8; write accepted in cycle N, we resume at N+1
    applyStimulus(1'b1, 12'h008, 32'd8, "");
    txDiv = 8;
    txMonEn = 1'b1;
    txExpQ.push_back(8'hA5);
    applyStimulus(1'b1, 12'h000, 32'hA5, "");
    repeat (20) @(negedge clk);
    applyStimulus(1'b1, 12'h000, 32'hFF, "");
    repeat (58) @(negedge clk);
    applyStimulus(1'b0, 12'h004, 32'h1, "tx_busy_cycle80");
    applyStimulus(1'b0, 12'h004, 32'h0, "tx_busy_clear_cycle81");
    repeat (30) @(negedge clk);
    checkOutput("tx_frame_count", txFrames, 32'd1);
    checkOutput("tx_line_idle", 32'(uart_tx), 32'd1);
    checkOutput("tx_exp_drained", txExpQ.size(), 32'd0);
    txMonEn = 1'b0;

    // RX loopback at DIV=16
    applyStimulus(1'b1, 12'h008, 32'd16, "");
    uartSend(8'h3C, 1'b1, 16);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 12'h004, 32'h2, "rx_status_nonempty");
    applyStimulus(1'b0, 12'h000, 32'h8000_003C, "rx_data");
    applyStimulus(1'b0, 12'h000, 32'h0, "rx_data_empty");
    applyStimulus(1'b0, 12'h004, 32'h0, "rx_status_after_pop");

    // Overrun: five bytes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) uartSend(8'(i), 1'b1, 16);
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 12'h004, 32'h0E, "ovr_status");
    applyStimulus(1'b1, 12'h004, 32'h08, "");
    applyStimulus(1'b0, 12'h004, 32'h06, "ovr_cleared");
    for (int i = 1; i <= 4; i++)
      applyStimulus(1'b0, 12'h000, 32'h8000_0000 | 32'(i), $sformatf("ovr_pop%0d", i));
    applyStimulus(1'b0, 12'h004, 32'h0, "ovr_status_empty");

    // Short glitch, then a frame with a bad stop bit
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    applyStimulus(1'b0, 12'h004, 32'h0, "glitch_status");
    uartSend(8'h55, 1'b0, 16);
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 12'h004, 32'h10, "ferr_status");
    applyStimulus(1'b0, 12'h000, 32'h0, "ferr_fifo_empty");
    applyStimulus(1'b1, 12'h004, 32'h10, "");
    applyStimulus(1'b0, 12'h004, 32'h0, "ferr_cleared");

    // Interrupt follows FIFO occupancy with one register stage
    applyStimulus(1'b1, 12'h00C, 32'h1, "");
    uartSend(8'h5A, 1'b1, 16);
    checkOutput("irq_raised", 32'(irq), 32'd1);
    applyStimulus(1'b0, 12'h000, 32'h8000_005A, "irq_data");
    checkOutput("irq_hold_n1", 32'(irq), 32'd1);
    @(negedge clk);
    checkOutput("irq_cleared_n2", 32'(irq), 32'd0);

    // Reset in the middle of a TX frame
    applyStimulus(1'b1, 12'h000, 32'h00, "");
    repeat (20) @(negedge clk);
    checkOutput("rst_tx_midframe_low", 32'(uart_tx), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_uart_tx", 32'(uart_tx), 32'd1);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_rsp_ready", 32'(mem_rsp_ready), 32'd0);
    applyStimulus(1'b0, 12'h004, 32'h0, "rst_status");
    applyStimulus(1'b0, 12'h008, 32'h0000_01B2, "rst_div");
    applyStimulus(1'b0, 12'h00C, 32'h0, "rst_irq_en");

    for (int w = 0; w < 20 && rdExpQ.size() != 0; w++) @(negedge clk);
    checkOutput("rsp_drain", rdExpQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_periph.md
# uart_periph

Memory-mapped 8N1 UART slave on the CPU data bus, sitting directly behind the SoC address decoder alongside the GPIO block. It consumes the decoded `mem_cmd_*` strobes for its 4 KB window and returns read data on the shared `mem_rsp_*` path. The block contains:
- a transmit shifter;
- an oversampling-free, mid-bit-sampling receiver;
- a small RX FIFO;
- a level interrupt intended for the CPU `irq` vector.

## Interface
Parameters:
- `CLK_DIV_DEFAULT`, 434: reset value of the baud divisor, in clk cycles per bit.
- `RX_FIFO_DEPTH`, 4: RX FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `mem_cmd_sel`  in  1  address decoder selects this block.
- `mem_cmd_valid`  in  1  command valid. Always accepted; the block never stalls.
- `mem_cmd_wr`  in  1  1 = write, 0 = read.
- `mem_cmd_addr`  in  12  byte offset within the window. Only [3:2] are decoded; [11:4] must be 0 for a hit.
- `mem_cmd_wdata`  in  32  write data.
- `mem_rsp_ready`  out  1  single-cycle read-response strobe.
- `mem_rsp_rdata`  out  32  read data. 0 whenever `mem_rsp_ready` = 0.
- `uart_tx`  out  1  serial output. Idle high.
- `uart_rx`  in  1  asynchronous serial input.
- `irq`  out  1  level interrupt.

## Operation
Accepted access: `mem_cmd_valid & mem_cmd_sel`.

Register map:
- 0x0 DATA
  - Write: bits[7:0] load TX if `tx_busy`=0. Ignored if busy.
  - Read: bit31 = FIFO non-empty, bits[7:0] = head byte. Pops only if non-empty. Empty read returns 0 and does not pop.
- 0x4 STATUS (read-only bits except where noted)
  - bit0 `tx_busy`
  - bit1 `rx_nonempty`
  - bit2 `rx_full`
  - bit3 `rx_overrun`: sticky.
  - bit4 `rx_frame_err`: sticky.
  - Writing 1 to bit3 or bit4 clears that bit. Other bits ignore writes.
- 0x8 DIV
  - bits[15:0] are R/W.
  - Values < 4 are stored as written but used as 4.
  - The divisor is latched by TX and RX independently at each frame start. A write mid-frame affects the next frame only.
- 0xC IRQ_EN
  - bit0 `rx_irq_en`.
  - `irq = rx_irq_en & rx_nonempty`, registered.
- Unmapped offsets: reads return 0 with normal response; writes are no-ops.

TX state machine, IDLE → START → DATA → STOP → IDLE:
- Each state lasts exactly `div` cycles.
- DATA sends 8 bits, LSB first.
- `tx_busy` = state ≠ IDLE.

RX path:
- `uart_rx` passes through a 2-flop synchronizer, with the sync register resetting to 1.
- State machine: IDLE → START → DATA → STOP.
- IDLE: a synchronized 1→0 transition enters START.
- START: waits `div/2` (floor) cycles, then samples.
  - Sample = 1: glitch, return to IDLE.
  - Sample = 0: enter DATA.
- DATA: samples 8 bits, LSB first, each `div` cycles after the previous sample.
- STOP: samples after `div` more cycles.
  - Stop = 1: push the byte. If the FIFO is full, drop the byte and set `rx_overrun`.
  - Stop = 0: discard the byte and set `rx_frame_err`.
  - In both cases RX returns to IDLE and can detect a new falling edge on the next cycle.

FIFO:
- A push and a pop in the same cycle both take effect; count is unchanged.
- A pop while full, simultaneous with a push, succeeds with no overrun.
- Pointers wrap modulo `RX_FIFO_DEPTH`.

Reset (also mid-frame), taking effect on the next cycle:
- Outputs: `uart_tx`=1, `mem_rsp_ready`=0, `mem_rsp_rdata`=0, `irq`=0.
- Both state machines return to IDLE.
- FIFO is emptied.
- Sticky bits are cleared.
- DIV = `CLK_DIV_DEFAULT`, IRQ_EN = 0.

## Timing
- Read accepted in cycle N:
  - `mem_rsp_ready`=1 and `mem_rsp_rdata` valid in cycle N+1, for exactly one cycle.
  - Back-to-back reads give back-to-back responses.
- Write accepted in cycle N: register updates visible to a read accepted in N+1. No response is generated.
- DATA pop on read accepted in N: `rx_nonempty` reflects the pop from cycle N+1.
- TX write accepted in cycle N:
  - `uart_tx` falls at N+1 and `tx_busy`=1 from N+1.
  - Frame spans 10·div cycles.
  - `tx_busy`=0 at N+1+10·div. A new write is accepted from that cycle.
- RX byte:
  - Pushed 3 cycles after the stop-bit sample point on raw `uart_rx` (2 cycles synchronizer, 1 cycle push).
  - `irq` rises 1 cycle after the push.

## Test plan
- **Reset values:** after reset, read 0x8 → 0x1B2; read 0x4 → 0; `uart_tx`=1; `irq`=0.
- **TX frame:** write DIV=8, then DATA=0xA5 → `uart_tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each held 8 cycles; `tx_busy` clears at cycle 81 after the write. A second write issued while busy is ignored (no second frame).
- **RX loopback:** DIV=16, drive 0x3C on `uart_rx` → STATUS bit1=1; DATA read returns 0x8000003C; a following DATA read returns 0x00000000.
- **FIFO overrun:** with DEPTH=4, send 5 bytes 0x01–0x05 with no reads → STATUS=0x0E; reads return 0x01..0x04 with bit31 set; write 0x8 to STATUS clears bit3.
- **Errors:** a 4-cycle low glitch at DIV=16 → no push, no error; a frame with stop bit=0 → STATUS bit4=1, FIFO empty.
- **IRQ and reset:** IRQ_EN=1, receive one byte → `irq`=1; pop via DATA read → `irq`=0 two cycles after acceptance; assert `reset` mid-TX frame → `uart_tx`=1 and `tx_busy`=0 on the next cycle.
